// File: rtl/decap_packet_mc.sv
// Multi-source reassembler: rebuilds one DFX frame per source from indexed Aurora beats.
// Define DECAP_ERR_CNT_EN to add saturating error counters on err_cnt (tied to 0 otherwise).
module decap_packet_mc #(
  parameter int unsigned DATA_WIDTH        = 1024,
  parameter int unsigned ADDR_WIDTH        = 10,
  parameter int unsigned AURORA_DATA_WIDTH = 64,
  parameter int unsigned HDR_WIDTH         = 9,
  parameter int unsigned NUM_SRC           = 4,
  parameter int unsigned IDX_W             = 5,
  localparam int unsigned FRAME_W          = DATA_WIDTH + ADDR_WIDTH,
  localparam int unsigned SRC_W            = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [AURORA_DATA_WIDTH-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [FRAME_W-1:0]           out_frame,
  output logic [SRC_W-1:0]             out_src,
  output logic                         err_drop,
  output logic                         err_dup,
  output logic                         err_idx,
  output logic [47:0]                  err_cnt
);

  localparam int unsigned PAY_W     = AURORA_DATA_WIDTH - HDR_WIDTH;
  localparam int unsigned NUM_BEATS = (FRAME_W + PAY_W - 1) / PAY_W;

  typedef enum logic {StCollect, StPending} src_state_e;

  src_state_e           state_q [NUM_SRC];
  logic [NUM_BEATS-1:0] bm_q    [NUM_SRC];
  logic [FRAME_W-1:0]   frame_q [NUM_SRC];
  logic [SRC_W-1:0]     rr_q;

  logic [SRC_W-1:0] in_src;
  logic [IDX_W-1:0] in_idx;
  logic [PAY_W-1:0] in_pay;

  assign in_src = in_data[SRC_W-1:0];
  assign in_idx = in_data[SRC_W+IDX_W-1:SRC_W];
  assign in_pay = in_data[AURORA_DATA_WIDTH-1:HDR_WIDTH];

  if (HDR_WIDTH > SRC_W + IDX_W) begin : g_hdr_spare
    logic unused_hdr;
    assign unused_hdr = ^in_data[HDR_WIDTH-1:SRC_W+IDX_W];
  end

  // Beat decode and slice write-enable generation
  logic                 idx_bad, src_pend, beat_wr, beat_dup, beat_done;
  logic [NUM_BEATS-1:0] idx_oh, cur_bm, bm_next;
  logic [31:0]          shamt;
  logic [FRAME_W-1:0]   wr_mask, wr_data;

  always_comb begin
    idx_bad = 32'(in_idx) >= NUM_BEATS;
    idx_oh  = '0;
    for (int k = 0; k < NUM_BEATS; k++) begin
      idx_oh[k] = (32'(in_idx) == 32'(k));
    end
    src_pend  = (state_q[in_src] == StPending);
    cur_bm    = bm_q[in_src];
    bm_next   = cur_bm | idx_oh;
    beat_wr   = in_valid && !idx_bad && !src_pend;
    beat_dup  = beat_wr && |(cur_bm & idx_oh);
    beat_done = beat_wr && (&bm_next);
    // Bits shifted past FRAME_W fall off, which trims the short last beat.
    shamt   = 32'(in_idx) * PAY_W;
    wr_mask = {{(FRAME_W-PAY_W){1'b0}}, {PAY_W{1'b1}}} << shamt;
    wr_data = {{(FRAME_W-PAY_W){1'b0}}, in_pay} << shamt;
  end

  // Round-robin pick among pending sources, starting at rr_q
  logic             out_free, found, load;
  logic [SRC_W-1:0] win, cand, rr_next;

  always_comb begin
    out_free = !out_valid || out_ready;
    found    = 1'b0;
    win      = '0;
    cand     = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      cand = SRC_W'((32'(rr_q) + 32'(i)) % NUM_SRC);
      if (!found && state_q[cand] == StPending) begin
        found = 1'b1;
        win   = cand;
      end
    end
    load    = out_free && found;
    rr_next = SRC_W'((32'(win) + 32'd1) % NUM_SRC);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_SRC; s++) begin
        state_q[s] <= StCollect;
        bm_q[s]    <= '0;
        frame_q[s] <= '0;
      end
      rr_q      <= '0;
      out_valid <= 1'b0;
      out_frame <= '0;
      out_src   <= '0;
      err_drop  <= 1'b0;
      err_dup   <= 1'b0;
      err_idx   <= 1'b0;
    end else begin
      err_idx  <= in_valid && idx_bad;
      err_drop <= in_valid && !idx_bad && src_pend;
      err_dup  <= beat_dup;

      // A winner is pending, so it can never also take a beat this cycle.
      for (int s = 0; s < NUM_SRC; s++) begin
        if (load && win == SRC_W'(s)) begin
          state_q[s] <= StCollect;
          frame_q[s] <= '0;
        end else if (beat_wr && in_src == SRC_W'(s)) begin
          frame_q[s] <= (frame_q[s] & ~wr_mask) | wr_data;
          if (beat_done) begin
            state_q[s] <= StPending;
            bm_q[s]    <= '0;
          end else begin
            bm_q[s] <= bm_next;
          end
        end
      end

      if (load) begin
        out_valid <= 1'b1;
        out_frame <= frame_q[win];
        out_src   <= win;
        rr_q      <= rr_next;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef DECAP_ERR_CNT_EN
  logic [15:0] idx_cnt, dup_cnt, drop_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_cnt  <= '0;
      dup_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (err_idx && idx_cnt != 16'hFFFF) idx_cnt <= idx_cnt + 16'd1;
      if (err_dup && dup_cnt != 16'hFFFF) dup_cnt <= dup_cnt + 16'd1;
      if (err_drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  assign err_cnt = {idx_cnt, dup_cnt, drop_cnt};
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_decap_packet_mc.sv
// Self-checking bench for decap_packet_mc: directed scenarios plus randomized traffic
// checked against a per-source frame model and an expected-frame scoreboard.
module tb_decap_packet_mc;

  localparam int FW = 1034;
  localparam int PW = 55;
  localparam int NB = 19;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [63:0]   in_data = '0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [FW-1:0] out_frame;
  logic [1:0]    out_src;
  logic          err_drop, err_dup, err_idx;
  logic [47:0]   err_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  decap_packet_mc dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_frame (out_frame),
    .out_src   (out_src),
    .err_drop  (err_drop),
    .err_dup   (err_dup),
    .err_idx   (err_idx),
    .err_cnt   (err_cnt)
  );

  function automatic logic [PW-1:0] rnd_pay();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[PW-1:0];
  endfunction

  // Header spare bits (8:7) are filled with noise; the design must ignore them.
  function automatic logic [63:0] mk_beat(int src, int idx, logic [PW-1:0] pay);
    logic [1:0] s;
    logic [4:0] i;
    logic [1:0] spare;
    s     = 2'(src);
    i     = 5'(idx);
    spare = 2'($urandom_range(0, 3));
    return {pay, spare, i, s};
  endfunction

  function automatic string frame_diff(logic [FW-1:0] a, logic [FW-1:0] b);
    logic [NB*PW-1:0] wa, wb;
    wa = {{(NB*PW-FW){1'b0}}, a};
    wb = {{(NB*PW-FW){1'b0}}, b};
    for (int k = 0; k < NB; k++) begin
      if (wa[k*PW +: PW] !== wb[k*PW +: PW])
        return $sformatf("slice %0d got %h exp %h", k, wa[k*PW +: PW], wb[k*PW +: PW]);
    end
    return "no slice differs";
  endfunction

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(int src, int idx, logic [PW-1:0] pay);
    in_valid = 1'b1;
    in_data  = mk_beat(src, idx, pay);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(int budget);
    int t;
    t = 0;
    while (!out_valid && t < budget) begin
      tick(1);
      t++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    n_tests++;
    if (out_frame !== '0) begin n_fail++; $display("FAIL reset_frame got nonzero exp 0"); end
    n_tests++;
    if (out_src !== 2'd0) begin n_fail++; $display("FAIL reset_src got %0d exp 0", out_src); end
    n_tests++;
    if ({err_drop, err_dup, err_idx} !== 3'b000) begin
      n_fail++; $display("FAIL reset_pulses got %b exp 000", {err_drop, err_dup, err_idx});
    end
    n_tests++;
    if (err_cnt !== 48'd0) begin n_fail++; $display("FAIL reset_cnt got %h exp 0", err_cnt); end
    rst = 1'b0;
    tick(1);
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_valid got %b exp 0", out_valid); end
  endtask

  task automatic test_in_order();
    logic [NB*PW-1:0] w;
    int pulses;
    w = '0;
    pulses = 0;
    out_ready = 1'b0;
    for (int k = 0; k < NB; k++) begin
      w[k*PW +: PW] = PW'(k);
      send(2, k, PW'(k));
      if (err_drop || err_dup || err_idx) pulses++;
    end
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL inorder_early_valid got %b exp 0", out_valid); end
    tick(1);
    n_tests++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL inorder_latency got %b exp 1", out_valid); end
    n_tests++;
    if (out_src !== 2'd2) begin n_fail++; $display("FAIL inorder_src got %0d exp 2", out_src); end
    n_tests++;
    if (out_frame !== w[FW-1:0]) begin
      n_fail++; $display("FAIL inorder_frame %s", frame_diff(out_frame, w[FW-1:0]));
    end
    n_tests++;
    if (pulses != 0) begin n_fail++; $display("FAIL inorder_pulses got %0d exp 0", pulses); end
    out_ready = 1'b1;
    tick(1);
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL inorder_consume got %b exp 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_interleave();
    logic [NB*PW-1:0] w0, w3;
    logic [PW-1:0] p;
    w0 = '0;
    w3 = '0;
    out_ready = 1'b0;
    for (int k = NB - 1; k >= 0; k--) begin
      p = rnd_pay(); w0[k*PW +: PW] = p; send(0, k, p);
      p = rnd_pay(); w3[k*PW +: PW] = p; send(3, k, p);
    end
    wait_valid(8);
    n_tests++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ilv_first_valid got %b exp 1", out_valid); end
    tick(2);
    n_tests++;
    if (out_src !== 2'd0) begin n_fail++; $display("FAIL ilv_first_src got %0d exp 0", out_src); end
    n_tests++;
    if (out_frame !== w0[FW-1:0]) begin
      n_fail++; $display("FAIL ilv_frame0 %s", frame_diff(out_frame, w0[FW-1:0]));
    end
    out_ready = 1'b1;
    tick(1);
    n_tests++;
    if (out_valid !== 1'b1 || out_src !== 2'd3) begin
      n_fail++; $display("FAIL ilv_second got valid=%b src=%0d exp valid=1 src=3", out_valid, out_src);
    end
    n_tests++;
    if (out_frame !== w3[FW-1:0]) begin
      n_fail++; $display("FAIL ilv_frame3 %s", frame_diff(out_frame, w3[FW-1:0]));
    end
    tick(1);
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ilv_drain got %b exp 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_drop();
    logic [NB*PW-1:0] w0, w1;
    logic [PW-1:0] p;
    int drops, moved, pulses;
    w0 = '0;
    w1 = '0;
    drops = 0;
    moved = 0;
    pulses = 0;
    out_ready = 1'b0;
    for (int k = 0; k < NB; k++) begin p = rnd_pay(); w0[k*PW +: PW] = p; send(0, k, p); end
    tick(1);
    for (int k = 0; k < NB; k++) begin p = rnd_pay(); w1[k*PW +: PW] = p; send(1, k, p); end
    tick(1);
    for (int j = 0; j < 3; j++) begin
      send(1, j + 2, rnd_pay());
      if (err_drop === 1'b1) drops++;
      if (out_src !== 2'd0 || out_frame !== w0[FW-1:0] || out_valid !== 1'b1) moved++;
    end
    n_tests++;
    if (drops != 3) begin n_fail++; $display("FAIL drop_pulses got %0d exp 3", drops); end
    n_tests++;
    if (moved != 0) begin n_fail++; $display("FAIL drop_hold got %0d changes exp 0", moved); end
    out_ready = 1'b1;
    tick(1);
    n_tests++;
    if (out_valid !== 1'b1 || out_src !== 2'd1) begin
      n_fail++; $display("FAIL drop_src1 got valid=%b src=%0d exp valid=1 src=1", out_valid, out_src);
    end
    n_tests++;
    if (out_frame !== w1[FW-1:0]) begin
      n_fail++; $display("FAIL drop_frame1 %s", frame_diff(out_frame, w1[FW-1:0]));
    end
    tick(1);
    w1 = '0;
    for (int k = NB - 1; k >= 0; k--) begin
      p = rnd_pay(); w1[k*PW +: PW] = p; send(1, k, p);
      if (err_drop || err_dup || err_idx) pulses++;
    end
    wait_valid(8);
    n_tests++;
    if (out_valid !== 1'b1 || out_src !== 2'd1 || out_frame !== w1[FW-1:0]) begin
      n_fail++; $display("FAIL drop_next_frame got valid=%b src=%0d (%s) exp valid=1 src=1",
                         out_valid, out_src, frame_diff(out_frame, w1[FW-1:0]));
    end
    n_tests++;
    if (pulses != 0) begin n_fail++; $display("FAIL drop_next_pulses got %0d exp 0", pulses); end
    tick(1);
  endtask

  task automatic test_idx_dup();
    logic [NB*PW-1:0] w;
    logic [PW-1:0] p;
    w = '0;
    out_ready = 1'b1;
    send(0, 25, rnd_pay());
    n_tests++;
    if ({err_idx, err_dup, err_drop} !== 3'b100) begin
      n_fail++; $display("FAIL idx_pulse got idx/dup/drop=%b exp 100", {err_idx, err_dup, err_drop});
    end
    for (int k = 0; k < NB; k++) begin
      p = rnd_pay(); w[k*PW +: PW] = p; send(0, k, p);
      if (k == 4) begin
        p = rnd_pay(); w[k*PW +: PW] = p; send(0, 4, p);
        n_tests++;
        if ({err_idx, err_dup, err_drop} !== 3'b010) begin
          n_fail++; $display("FAIL dup_pulse got idx/dup/drop=%b exp 010", {err_idx, err_dup, err_drop});
        end
      end
    end
    wait_valid(8);
    n_tests++;
    if (out_valid !== 1'b1 || out_src !== 2'd0 || out_frame !== w[FW-1:0]) begin
      n_fail++; $display("FAIL dup_frame got valid=%b src=%0d (%s) exp valid=1 src=0",
                         out_valid, out_src, frame_diff(out_frame, w[FW-1:0]));
    end
    tick(1);
  endtask

  task automatic test_reset_mid();
    logic [NB*PW-1:0] w;
    logic [PW-1:0] p;
    int dups, early;
    w = '0;
    dups = 0;
    early = 0;
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) send(2, k, rnd_pay());
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    n_tests++;
    if (err_cnt !== 48'd0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_state got cnt=%h valid=%b exp 0/0", err_cnt, out_valid);
    end
    for (int k = 10; k < NB; k++) begin
      p = rnd_pay(); w[k*PW +: PW] = p; send(2, k, p);
      if (err_dup) dups++;
      if (out_valid) early++;
    end
    tick(2);
    if (out_valid) early++;
    n_tests++;
    if (early != 0) begin n_fail++; $display("FAIL rstmid_stale_frame got %0d valids exp 0", early); end
    for (int k = 0; k < 10; k++) begin
      p = rnd_pay(); w[k*PW +: PW] = p; send(2, k, p);
      if (err_dup) dups++;
    end
    wait_valid(8);
    n_tests++;
    if (out_valid !== 1'b1 || out_src !== 2'd2 || out_frame !== w[FW-1:0]) begin
      n_fail++; $display("FAIL rstmid_frame got valid=%b src=%0d (%s) exp valid=1 src=2",
                         out_valid, out_src, frame_diff(out_frame, w[FW-1:0]));
    end
    n_tests++;
    if (dups != 0) begin n_fail++; $display("FAIL rstmid_dups got %0d exp 0", dups); end
    tick(1);
  endtask

  typedef struct {
    int            src;
    logic [FW-1:0] frame;
  } exp_t;

  task automatic test_random();
    logic [NB*PW-1:0] mw [4];
    bit   [NB-1:0]    got [4];
    int               cool [4];
    exp_t             expq [$];
    exp_t             e;
    logic [PW-1:0]    p;
    logic             exp_idx, exp_dup;
    int               s, idx, pos, frames;
    frames = 0;
    for (int i = 0; i < 4; i++) begin mw[i] = '0; got[i] = '0; cool[i] = 0; end
    out_ready = 1'b1;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      exp_idx = 1'b0;
      exp_dup = 1'b0;
      if (cyc < 3950 && $urandom_range(0, 3) != 0) begin
        s = int'($urandom_range(0, 3));
        if (cool[s] == 0) begin
          idx = ($urandom_range(0, 15) == 0) ? int'($urandom_range(NB, 31))
                                             : int'($urandom_range(0, NB - 1));
          p = rnd_pay();
          in_valid = 1'b1;
          in_data  = mk_beat(s, idx, p);
          if (idx >= NB) begin
            exp_idx = 1'b1;
          end else begin
            exp_dup = got[s][idx];
            got[s][idx] = 1'b1;
            mw[s][idx*PW +: PW] = p;
            if (&got[s]) begin
              e.src = s;
              e.frame = mw[s][FW-1:0];
              expq.push_back(e);
              got[s] = '0;
              mw[s] = '0;
              cool[s] = 12;
            end
          end
        end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) if (cool[i] > 0) cool[i]--;
      n_tests++;
      if ({err_idx, err_dup, err_drop} !== {exp_idx, exp_dup, 1'b0}) begin
        n_fail++; $display("FAIL rnd_pulses cyc %0d got idx/dup/drop=%b exp %b", cyc,
                           {err_idx, err_dup, err_drop}, {exp_idx, exp_dup, 1'b0});
      end
      if (out_valid) begin
        pos = -1;
        for (int i = 0; i < expq.size(); i++) begin
          if (pos < 0 && expq[i].src == int'(out_src)) pos = i;
        end
        n_tests++;
        if (pos < 0) begin
          n_fail++; $display("FAIL rnd_unexpected cyc %0d got src %0d exp no frame", cyc, out_src);
        end else begin
          if (out_frame !== expq[pos].frame) begin
            n_fail++; $display("FAIL rnd_frame cyc %0d src %0d %s", cyc, out_src,
                               frame_diff(out_frame, expq[pos].frame));
          end
          expq.delete(pos);
          frames++;
        end
      end
    end
    n_tests++;
    if (expq.size() != 0) begin n_fail++; $display("FAIL rnd_missing got %0d left exp 0", expq.size()); end
    n_tests++;
    if (frames < 5) begin n_fail++; $display("FAIL rnd_frames got %0d exp >=5", frames); end
  endtask

  task automatic test_counters();
`ifdef DECAP_ERR_CNT_EN
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    for (int j = 0; j < 5; j++) send(0, 31, rnd_pay());
    send(0, 0, rnd_pay());
    send(0, 0, rnd_pay());
    tick(2);
    n_tests++;
    if (err_cnt !== {16'd5, 16'd1, 16'd0}) begin
      n_fail++; $display("FAIL cnt_small got %h exp 000500010000", err_cnt);
    end
    in_valid = 1'b1;
    in_data  = mk_beat(1, 20, rnd_pay());
    repeat (70000) @(posedge clk);
    #1;
    in_valid = 1'b0;
    tick(2);
    n_tests++;
    if (err_cnt[47:32] !== 16'hFFFF) begin
      n_fail++; $display("FAIL cnt_saturate got %h exp ffff", err_cnt[47:32]);
    end
    n_tests++;
    if (err_cnt[31:0] !== {16'd1, 16'd0}) begin
      n_fail++; $display("FAIL cnt_others got %h exp 00010000", err_cnt[31:0]);
    end
`else
    send(0, 31, rnd_pay());
    send(0, 31, rnd_pay());
    tick(2);
    n_tests++;
    if (err_cnt !== 48'd0) begin n_fail++; $display("FAIL cnt_tied got %h exp 0", err_cnt); end
`endif
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_interleave();
    test_drop();
    test_idx_dup();
    test_reset_mid();
    test_random();
    test_counters();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
